// File: rtl/rs232_tx.sv
// UART 8N1 transmitter with a small write FIFO and selectable bit rate.
// Define RS232T_PARITY_EN to insert an even-parity bit (8E1 frames).
module rs232_tx #(
  parameter int unsigned CLK_DIV_SLOW = 217,
  parameter int unsigned CLK_DIV_FAST = 109,
  parameter int unsigned DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fsel,
  input  logic       start,
  input  logic [7:0] data,
  output logic       rdy,
  output logic       busy,
  output logic       TxD
);

  localparam int unsigned DivMax = (CLK_DIV_SLOW > CLK_DIV_FAST) ? CLK_DIV_SLOW : CLK_DIV_FAST;
  localparam int unsigned TickW  = $clog2(DivMax + 1);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

`ifdef RS232T_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // FIFO
  logic [7:0]      mem [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push, pop, empty;
  logic [7:0]      head;

  assign rdy   = (cnt_q != Full);
  assign empty = (cnt_q == '0);
  assign push  = start & rdy;
  assign head  = mem[rptr_q];

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: ;
      endcase
    end
  end

  // Transmit FSM
  state_e           state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d, limit_q, limit_d, sel_limit;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             txd_q, txd_d;
  logic             at_limit;
`ifdef RS232T_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign sel_limit = fsel ? TickW'(CLK_DIV_FAST) : TickW'(CLK_DIV_SLOW);
  assign at_limit  = (tick_q == limit_q);
  assign TxD       = txd_q;
  assign busy      = (state_q != StIdle) || !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      limit_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      txd_q    <= 1'b1;
`ifdef RS232T_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      limit_q  <= limit_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      txd_q    <= txd_d;
`ifdef RS232T_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = at_limit ? '0 : tick_q + TickW'(1);
    limit_d  = limit_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    txd_d    = txd_q;
    pop      = 1'b0;
`ifdef RS232T_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        txd_d  = 1'b1;
        tick_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          limit_d = sel_limit;
          txd_d   = 1'b0;
          state_d = StStart;
`ifdef RS232T_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      StStart: begin
        if (at_limit) begin
          txd_d    = shreg_q[0];
          bitcnt_d = '0;
          state_d  = StData;
        end
      end
      StData: begin
        if (at_limit) begin
          if (bitcnt_q == 3'd7) begin
`ifdef RS232T_PARITY_EN
            txd_d   = parity_q;
            state_d = StParity;
`else
            txd_d   = 1'b1;
            state_d = StStop;
`endif
          end else begin
            shreg_d  = shreg_q >> 1;
            txd_d    = shreg_q[1];
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
`ifdef RS232T_PARITY_EN
      StParity: begin
        if (at_limit) begin
          txd_d   = 1'b1;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (at_limit) begin
          if (!empty) begin
            // Back-to-back frame: rate is re-latched here so fsel applies per frame.
            pop     = 1'b1;
            shreg_d = head;
            limit_d = sel_limit;
            txd_d   = 1'b0;
            state_d = StStart;
`ifdef RS232T_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_rs232_tx.sv
// Directed self-checking bench for rs232_tx (default parameters, 8N1 or 8E1 build).
module tb_rs232_tx;
  localparam int LS = 218;
  localparam int LF = 110;

  logic       clk = 1'b0;
  logic       rst, fsel, start;
  logic [7:0] data;
  logic       rdy, busy, TxD;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rs232_tx dut (
    .clk  (clk),
    .rst  (rst),
    .fsel (fsel),
    .start(start),
    .data (data),
    .rdy  (rdy),
    .busy (busy),
    .TxD  (TxD)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_fall(input int budget, output int e);
    e = -1;
    for (int i = 0; i < budget; i++) begin
      if (TxD === 1'b0) begin
        e = cyc;
        return;
      end
      step();
    end
  endtask

  // Samples bit k of a frame starting at edge e in the middle of its bit period.
  task automatic capture(input int e, input int l, input int first, input int nbits,
                         output logic [10:0] bits);
    bits = '1;
    for (int k = first; k < nbits; k++) begin
      goto(e + k * l + l / 2);
      bits[k] = TxD;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fsel = 1'b0; start = 1'b0; data = 8'h00;
    #5;
    total++;
    if ({TxD, rdy, busy} !== 3'b110) begin
      bad++; $display("FAIL reset: got TxD/rdy/busy=%b want 110", {TxD, rdy, busy});
    end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_slow();
    logic [10:0] b;
    logic [9:0]  exp;
    int          c0, e;
    fsel = 1'b0; c0 = cyc;
    data = 8'h55; start = 1'b1; step(); start = 1'b0;
    total++;
    if ({TxD, busy} !== 2'b11) begin
      bad++; $display("FAIL single_push: got TxD/busy=%b want 11", {TxD, busy});
    end
    wait_fall(10, e);
    total++;
    if (e != c0 + 2) begin
      bad++; $display("FAIL single_latency: got fall edge %0d want %0d", e, c0 + 2);
    end
    if (e < 0) return;
    goto(e + LS - 1);
    total++;
    if (TxD !== 1'b0) begin
      bad++; $display("FAIL single_start_end: got %b want 0", TxD);
    end
    step();
    total++;
    if (TxD !== 1'b1) begin
      bad++; $display("FAIL single_bit0_begin: got %b want 1", TxD);
    end
    capture(e, LS, 1, 10, b);
    exp = {1'b1, 8'h55, 1'b0};
    total++;
    if (b[9:1] !== exp[9:1]) begin
      bad++; $display("FAIL single_frame: got %b want %b", b[9:1], exp[9:1]);
    end
    goto(e + 10 * LS - 1);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL single_busy_stop: got %b want 1", busy);
    end
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL single_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] b;
    logic [9:0]  exp;
    int          e1, e2;
    fsel = 1'b1;
    data = 8'hA3; start = 1'b1; step();
    data = 8'h0F; step(); start = 1'b0;
    wait_fall(10, e1);
    total++;
    if (e1 < 0) begin
      bad++; $display("FAIL b2b_fall: got no start bit want one"); return;
    end
    capture(e1, LF, 0, 10, b);
    exp = {1'b1, 8'hA3, 1'b0};
    total++;
    if (b[9:0] !== exp) begin
      bad++; $display("FAIL b2b_frame1: got %b want %b", b[9:0], exp);
    end
    goto(e1 + 10 * LF - 1);
    total++;
    if (TxD !== 1'b1) begin
      bad++; $display("FAIL b2b_stop1: got %b want 1", TxD);
    end
    step();
    total++;
    if (TxD !== 1'b0) begin
      bad++; $display("FAIL b2b_gapless: got %b want 0", TxD);
    end
    e2 = e1 + 10 * LF;
    capture(e2, LF, 0, 10, b);
    exp = {1'b1, 8'h0F, 1'b0};
    total++;
    if (b[9:0] !== exp) begin
      bad++; $display("FAIL b2b_frame2: got %b want %b", b[9:0], exp);
    end
    goto(e2 + 10 * LF);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_fifo_full();
    logic [10:0] b;
    logic [9:0]  exp;
    logic [7:0]  d;
    int          c0, e, lows;
    fsel = 1'b1; c0 = cyc; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = 8'(i + 1);
      step();
      total++;
      if (rdy !== (i < 4)) begin
        bad++; $display("FAIL full_rdy_%0d: got %b want %b", i, rdy, i < 4);
      end
    end
    start = 1'b0;
    e = c0 + 2;
    for (int k = 0; k < 5; k++) begin
      capture(e + k * 10 * LF, LF, 0, 10, b);
      d = 8'(k + 1);
      exp = {1'b1, d, 1'b0};
      total++;
      if (b[9:0] !== exp) begin
        bad++; $display("FAIL full_frame_%0d: got %b want %b", k, b[9:0], exp);
      end
      if (k == 0) begin
        goto(e + 10 * LF - 1);
        total++;
        if (rdy !== 1'b0) begin
          bad++; $display("FAIL full_rdy_hold: got %b want 0", rdy);
        end
        step();
        total++;
        if (rdy !== 1'b1) begin
          bad++; $display("FAIL full_rdy_free: got %b want 1", rdy);
        end
      end
    end
    goto(e + 50 * LF);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL full_busy_end: got %b want 0", busy);
    end
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      if (TxD !== 1'b1) lows++;
      step();
    end
    total++;
    if (lows != 0) begin
      bad++; $display("FAIL full_dropped: got %0d low cycles want 0", lows);
    end
  endtask

  task automatic test_fsel_change();
    logic [10:0] b1, b2;
    logic [9:0]  exp;
    int          c0, e, e2;
    fsel = 1'b0; c0 = cyc;
    data = 8'h80; start = 1'b1; step();
    data = 8'h3C; step(); start = 1'b0;
    e = c0 + 2;
    fork
      capture(e, LS, 0, 10, b1);
      begin
        goto(e + 3 * LS + 100);
        fsel = 1'b1;
      end
    join
    exp = {1'b1, 8'h80, 1'b0};
    total++;
    if (b1[9:0] !== exp) begin
      bad++; $display("FAIL fsel_frame1: got %b want %b", b1[9:0], exp);
    end
    e2 = e + 10 * LS;
    goto(e2 - 1);
    total++;
    if (TxD !== 1'b1) begin
      bad++; $display("FAIL fsel_stop1: got %b want 1", TxD);
    end
    step();
    total++;
    if (TxD !== 1'b0) begin
      bad++; $display("FAIL fsel_start2: got %b want 0", TxD);
    end
    capture(e2, LF, 0, 10, b2);
    exp = {1'b1, 8'h3C, 1'b0};
    total++;
    if (b2[9:0] !== exp) begin
      bad++; $display("FAIL fsel_frame2: got %b want %b", b2[9:0], exp);
    end
    goto(e2 + 10 * LF);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL fsel_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int c0, e, errs;
    fsel = 1'b1; c0 = cyc; start = 1'b1;
    data = 8'hFF; step();
    data = 8'hAA; step();
    data = 8'hBB; step();
    start = 1'b0;
    e = c0 + 2;
    goto(e + 4 * LF + 50);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre_busy: got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({TxD, rdy, busy} !== 3'b110) begin
      bad++; $display("FAIL rstmid_async: got TxD/rdy/busy=%b want 110", {TxD, rdy, busy});
    end
    step(); step();
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (TxD !== 1'b1 || busy !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", errs);
    end
  endtask

  task automatic test_parity();
    logic [10:0] b, exp;
    int          c0, e, nb, len;
    fsel = 1'b0; c0 = cyc;
    data = 8'h07; start = 1'b1; step(); start = 1'b0;
`ifdef RS232T_PARITY_EN
    nb = 11; exp = {2'b11, 8'h07, 1'b0};
`else
    nb = 10; exp = {2'b11, 8'h07, 1'b0};
`endif
    len = nb * LS;
    wait_fall(10, e);
    total++;
    if (e != c0 + 2) begin
      bad++; $display("FAIL par_latency: got fall edge %0d want %0d", e, c0 + 2);
    end
    if (e < 0) return;
    capture(e, LS, 0, nb, b);
    total++;
    if (b !== exp) begin
      bad++; $display("FAIL par_frame: got %b want %b", b, exp);
    end
    goto(e + len - 1);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL par_len_busy: got %b want 1", busy);
    end
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL par_len_end: got %b want 0 at %0d cycles", busy, len);
    end
  endtask

  initial begin
    test_reset();
    test_single_slow();
    step();
    test_back_to_back();
    step();
    test_fifo_full();
    test_fsel_change();
    step();
    test_reset_mid_frame();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
